// File: rtl/imem_loader.sv
// Boot-time loader: framed byte stream -> 32-bit words written into instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing 32-bit sum of the payload words.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 2 ** ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count,
    output logic [2:0]        dbg_state
);

    // Handshake: a byte moves on a rising edge where in_valid & in_ready are both 1;
    // in_ready never depends on in_valid, and in_data is only sampled on that edge.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_LOAD  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHK   = 3'd3,
`endif
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       MAX_L  = 32'(MAX_WORDS);

    state_t              state_q, state_d;
    logic [23:0]         shift_q, shift_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]     index_q, index_d;
    logic [31:0]         len_q, len_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]         sum_q, sum_d;
`endif

    logic        accept;
    logic        word_end;
    logic        last_word;
    logic [31:0] word;

    always_comb begin
        accept    = in_valid & in_ready_q;
        word      = {shift_q, in_data};
        word_end  = (byte_cnt_q == 2'd3);
        last_word = ((32'(index_q) + 32'd1) == len_q);

        state_d      = state_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        index_d      = index_q;
        len_d        = len_q;
        done_d       = done_q;
        error_d      = error_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        // A write issued last cycle is counted one edge after its final byte.
        word_count_d = word_count_q + {{ADDR_W{1'b0}}, mem_we_q};
`ifdef LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif

        if (accept) begin
            shift_d    = word[23:0];
            byte_cnt_d = byte_cnt_q + 2'd1;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d      = S_HDR;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    word_count_d = '0;
                    byte_cnt_d   = 2'd0;
                    index_d      = '0;
                    len_d        = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d        = '0;
`endif
                end
            end
            S_HDR: begin
                if (accept && word_end) begin
                    len_d = word;
                    if (word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
`endif
                    end else if (word > MAX_L) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept && word_end) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = BASE_A + index_q[ADDR_W-1:0];
                    mem_wdata_d = word;
                    index_d     = index_q + {{ADDR_W{1'b0}}, 1'b1};
`ifdef LOADER_CHECKSUM_EN
                    sum_d       = sum_q + word;
                    if (last_word) begin
                        state_d = S_CHK;
                    end
`else
                    if (last_word) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept && word_end) begin
                    if (word == sum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Ready/busy are registered from the next state so they move on the same edge.
`ifdef LOADER_CHECKSUM_EN
        in_ready_d = (state_d == S_HDR) || (state_d == S_LOAD) || (state_d == S_CHK);
`else
        in_ready_d = (state_d == S_HDR) || (state_d == S_LOAD);
`endif
        busy_d = in_ready_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            index_q      <= '0;
            len_q        <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            word_count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            index_q      <= index_d;
            len_q        <= len_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            word_count_q <= word_count_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = word_count_q;
    assign dbg_state  = state_q;

endmodule
